// File: rtl/pattern_detect_ctrl.sv
// Sequencer for the serial pattern detector. It clears the datapath and streams the host
// pattern MSB-first into the program register. It then gates, edge-detects and counts comparator matches.
module pattern_detect_ctrl #(
    parameter int N  = 1024,
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [W-1:0]  pat_word_i,
    input  logic          pat_valid_i,
    output logic          pat_ready_o,
    input  logic          dec_eq_i,
    output logic          dec_clr_o,
    output logic          dec_enable_o,
    output logic          dec_prgm_o,
    output logic          busy_o,
    output logic          armed_o,
    output logic          hit_o,
    output logic [CW-1:0] match_count_o
);
    localparam int NW  = N / W;
    localparam int WDW = $clog2(NW + 1);
    localparam int BLW = $clog2(W + 1);
    localparam int FW  = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DETECT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shifter_q, shifter_d;
    logic [BLW-1:0] bitsLeft_q, bitsLeft_d;
    logic [WDW-1:0] words_q, words_d;
    logic [FW-1:0]  fillCnt_q, fillCnt_d;
    logic [CW-1:0]  matchCount_q, matchCount_d;
    logic           decClr_q, decClr_d;
    logic           decEnable_q, decEnable_d;
    logic           decPrgm_q, decPrgm_d;
    logic           hit_q, hit_d;
    logic           eqPrev_q, eqPrev_d;
    logic           lastBit, loadRun, take, shiftBit, eqArmed;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lastBit = (words_q == WDW'(NW)) && (bitsLeft_q == BLW'(1));
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = CLEAR;
                CLEAR:   state_d = LOAD;
                LOAD: begin
                    if (start_i)      state_d = CLEAR;
                    else if (lastBit) state_d = DETECT;
                end
                DETECT:  if (start_i) state_d = CLEAR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Ready at one bit left lets the next word land as the last bit leaves, so the stream is gapless.
    always_comb begin
        busy_o        = (state_q != IDLE);
        armed_o       = (state_q == DETECT) && (fillCnt_q == FW'(N));
        pat_ready_o   = (state_q == LOAD) && (bitsLeft_q <= BLW'(1)) && (words_q < WDW'(NW));
        dec_clr_o     = decClr_q;
        dec_enable_o  = decEnable_q;
        dec_prgm_o    = decPrgm_q;
        hit_o         = hit_q;
        match_count_o = matchCount_q;
    end

    always_comb begin
        loadRun     = (state_q == LOAD) && !abort_i && !start_i;
        take        = loadRun && pat_valid_i && pat_ready_o;
        shiftBit    = loadRun && (bitsLeft_q != '0);
        shifter_d   = shifter_q;
        bitsLeft_d  = bitsLeft_q;
        words_d     = words_q;
        decEnable_d = shiftBit;
        decPrgm_d   = shiftBit && shifter_q[W-1];
        if (shiftBit) begin
            shifter_d  = shifter_q << 1;
            bitsLeft_d = bitsLeft_q - BLW'(1);
        end
        if (take) begin
            shifter_d  = pat_word_i;
            bitsLeft_d = BLW'(W);
            words_d    = words_q + WDW'(1);
        end
        if (state_q == CLEAR) begin
            bitsLeft_d = '0;
            words_d    = '0;
        end

        decClr_d  = (state_d == CLEAR);
        fillCnt_d = fillCnt_q;
        if (state_q == CLEAR) begin
            fillCnt_d = '0;
        end else if (!decClr_q && (state_q != IDLE) && (fillCnt_q != FW'(N))) begin
            fillCnt_d = fillCnt_q + FW'(1);
        end

        // A hit is a rising edge of the gated match, suppressed when leaving DETECT.
        eqArmed      = armed_o && dec_eq_i;
        eqPrev_d     = eqArmed;
        hit_d        = eqArmed && !eqPrev_q && (state_d == DETECT);
        matchCount_d = matchCount_q;
        if (state_q == CLEAR) begin
            matchCount_d = '0;
        end else if (hit_d && (matchCount_q != '1)) begin
            matchCount_d = matchCount_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            shifter_q    <= '0;
            bitsLeft_q   <= '0;
            words_q      <= '0;
            fillCnt_q    <= '0;
            matchCount_q <= '0;
            decClr_q     <= 1'b1;
            decEnable_q  <= 1'b0;
            decPrgm_q    <= 1'b0;
            hit_q        <= 1'b0;
            eqPrev_q     <= 1'b0;
        end else begin
            shifter_q    <= shifter_d;
            bitsLeft_q   <= bitsLeft_d;
            words_q      <= words_d;
            fillCnt_q    <= fillCnt_d;
            matchCount_q <= matchCount_d;
            decClr_q     <= decClr_d;
            decEnable_q  <= decEnable_d;
            decPrgm_q    <= decPrgm_d;
            hit_q        <= hit_d;
            eqPrev_q     <= eqPrev_d;
        end
    end
endmodule
